red_seq_unit: RTL and testbench

Multi-cycle, parametrised reduction unit for the Execute stage's RED instruction. It splits two DATA_W-bit operands into LANE_W-bit lanes and adds every lane of both operands into one exact sum, processing one lane pair per cycle. Lanes are treated as signed or unsigned, selected per operation. It generalises the fixed 4-bit CLA reduction slice to any lane width and lane count, and adds a start/ready/done handshake so Execute can stall on it.

---
 rtl/red_seq_unit.sv | 124 ++++++++++++
 tb/tb_red_seq_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_seq_unit.sv
// Sequential lane-sum reduction: adds every LANE_W-bit lane of A and B into one
// exact sum, one lane pair per cycle, with a start/ready/done handshake.
module red_seq_unit #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sgn,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ACC_W = LANE_W + 2 + $clog2(LANES);
    localparam int SUM_W = LANE_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sgn_q, sgn_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                done_q, done_d;

    logic [LANE_W-1:0]   a_lanes [LANES];
    logic [LANE_W-1:0]   b_lanes [LANES];
    logic [LANE_W-1:0]   a_l, b_l;
    logic [SUM_W-1:0]    a_ext, b_ext, lane_sum;
    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   res_sext, res_zext;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign a_lanes[gi] = a_q[gi*LANE_W +: LANE_W];
            assign b_lanes[gi] = b_q[gi*LANE_W +: LANE_W];
        end
    endgenerate

    assign a_l = a_lanes[idx_q];
    assign b_l = b_lanes[idx_q];

    // Two guard bits keep the unsigned pair sum non-negative once it is
    // sign-extended into the accumulator.
    assign a_ext    = {{2{sgn_q & a_l[LANE_W-1]}}, a_l};
    assign b_ext    = {{2{sgn_q & b_l[LANE_W-1]}}, b_l};
    assign lane_sum = a_ext + b_ext;
    assign acc_next = acc_q + ACC_W'($signed(lane_sum));
    assign res_sext = DATA_W'($signed(acc_next));
    assign res_zext = DATA_W'(acc_next);

    assign ready  = (state_q != ACCUM);
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = sgn;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(LANES - 1)) begin
                    result_d = sgn_q ? res_sext : res_zext;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_red_seq_unit.sv
// Scoreboard bench for red_seq_unit: directed vectors on the default build plus
// random regression on two other lane geometries against a lane-sum model.
module tb_red_seq_unit;
    localparam int LANES_M = 4;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-parameter DUT
    logic        rst_m = 1'b1, start_m = 1'b0, sgn_m = 1'b0;
    logic [15:0] a_m = '0, b_m = '0, result_m;
    logic        ready_m, done_m;
    red_seq_unit dut_m (.clk(clk), .rst(rst_m), .start(start_m), .sgn(sgn_m), .A(a_m), .B(b_m),
                        .ready(ready_m), .done(done_m), .result(result_m));

    // Regression DUTs share a reset separate from the directed one
    logic        rst_r = 1'b1;
    logic        start8 = 1'b0, sgn8 = 1'b0, ready8, done8;
    logic [15:0] a8 = '0, b8 = '0, result8;
    red_seq_unit #(.DATA_W(16), .LANE_W(8)) dut8 (.clk(clk), .rst(rst_r), .start(start8), .sgn(sgn8),
                        .A(a8), .B(b8), .ready(ready8), .done(done8), .result(result8));
    logic        start32 = 1'b0, sgn32 = 1'b0, ready32, done32;
    logic [31:0] a32 = '0, b32 = '0, result32;
    red_seq_unit #(.DATA_W(32), .LANE_W(4)) dut32 (.clk(clk), .rst(rst_r), .start(start32), .sgn(sgn32),
                        .A(a32), .B(b32), .ready(ready32), .done(done32), .result(result32));

    exp_t        q_main[$];
    logic [31:0] q8[$];
    logic [31:0] q32[$];
    bit          fin8 = 1'b0, fin32 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] red_model(input logic [31:0] a, input logic [31:0] b,
                                              input bit s, input int dw, input int lw);
        int          sum = 0;
        int          la, lb;
        logic [31:0] r;
        for (int i = 0; i < dw / lw; i++) begin
            la = int'((a >> (i * lw)) & ((32'h1 << lw) - 1));
            lb = int'((b >> (i * lw)) & ((32'h1 << lw) - 1));
            if (s && la >= (1 << (lw - 1))) la -= (1 << lw);
            if (s && lb >= (1 << (lw - 1))) lb -= (1 << lw);
            sum += la + lb;
        end
        r = 32'(sum);
        if (dw < 32) r = r & ((32'h1 << dw) - 1);
        return r;
    endfunction

    // Monitors: pop an expectation whenever a DUT pulses done
    exp_t e_m;
    always @(negedge clk) begin
        if (done_m) begin
            if (q_main.size() == 0) begin
                fail_evt("unexpected done on default DUT");
            end else begin
                e_m = q_main.pop_front();
                check({e_m.name, " result"}, 32'(result_m), e_m.res);
                check({e_m.name, " latency"}, 32'(cyc), 32'(e_m.cyc));
                $display("txn %s: result=0x%04h at cycle %0d", e_m.name, result_m, cyc);
            end
        end
    end

    logic [31:0] e8;
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) fail_evt("unexpected done on 16/8 DUT");
            else begin
                e8 = q8.pop_front();
                check("reg16x8 result", 32'(result8), e8);
                $display("txn reg16x8: A=0x%04h B=0x%04h sgn=%0d result=0x%04h", a8, b8, sgn8, result8);
            end
        end
    end

    logic [31:0] e32;
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) fail_evt("unexpected done on 32/4 DUT");
            else begin
                e32 = q32.pop_front();
                check("reg32x4 result", result32, e32);
                $display("txn reg32x4: A=0x%08h B=0x%08h sgn=%0d result=0x%08h", a32, b32, sgn32, result32);
            end
        end
    end

    task automatic wait_main_drain(input string name);
        int n = 0;
        while (q_main.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            fail_evt({"timeout ", name});
            q_main.delete();
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] exp, input string name);
        int n = 0;
        while (!ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) fail_evt({"ready timeout ", name});
        a_m = a; b_m = b; sgn_m = s; start_m = 1'b1;
        q_main.push_back('{32'(exp), cyc + 1 + LANES_M, name});
        @(negedge clk);
        start_m = 1'b0;
        check({name, " ready low while busy"}, 32'(ready_m), 32'd0);
        wait_main_drain(name);
    endtask

    // Random regression on the two alternate geometries
    initial begin
        logic [31:0] ra, rb;
        int          n;
        repeat (3) @(negedge clk);
        rst_r = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom;
            a8 = ra[15:0]; b8 = rb[15:0]; sgn8 = i[0]; start8 = 1'b1;
            q8.push_back(red_model({16'd0, ra[15:0]}, {16'd0, rb[15:0]}, i[0], 16, 8));
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (q8.size() != 0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (n == 30) begin
                fail_evt("timeout reg16x8");
                q8.delete();
            end
        end
        fin8 = 1'b1;
    end

    initial begin
        logic [31:0] ra, rb;
        int          n;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom;
            a32 = ra; b32 = rb; sgn32 = ~i[0]; start32 = 1'b1;
            q32.push_back(red_model(ra, rb, ~i[0], 32, 4));
            @(negedge clk);
            start32 = 1'b0;
            n = 0;
            while (q32.size() != 0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (n == 30) begin
                fail_evt("timeout reg32x4");
                q32.delete();
            end
        end
        fin32 = 1'b1;
    end

    // Directed sequence on the default DUT
    initial begin
        int c0;
        int n;
        repeat (2) @(negedge clk);
        rst_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle ready", 32'(ready_m), 32'd1);
            check("idle done", 32'(done_m), 32'd0);
            check("idle result", 32'(result_m), 32'd0);
        end

        do_op(16'h7777, 16'h7777, 1'b1, 16'h0038, "signed 7777");
        do_op(16'h8888, 16'h8888, 1'b1, 16'hFFC0, "signed 8888");
        do_op(16'h8888, 16'h8888, 1'b0, 16'h0040, "unsigned 8888");
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0078, "unsigned FFFF");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFF8, "signed FFFF");
        check("result holds after done", 32'(result_m), 32'h0000FFF8);

        // Back-to-back with start held high; second accept lands in DONE
        @(negedge clk);
        c0 = cyc;
        a_m = 16'h1234; b_m = 16'h0000; sgn_m = 1'b0; start_m = 1'b1;
        q_main.push_back('{32'h000A, c0 + 1 + LANES_M, "b2b first"});
        q_main.push_back('{32'h0002, c0 + 2 * (LANES_M + 1) + 1 - 1, "b2b second"});
        @(negedge clk);
        a_m = 16'h0001; b_m = 16'h0001;
        repeat (5) @(negedge clk);
        start_m = 1'b0;
        wait_main_drain("b2b");

        // Start pulses during ACCUM must be ignored
        @(negedge clk);
        a_m = 16'h1111; b_m = 16'h2222; sgn_m = 1'b0; start_m = 1'b1;
        q_main.push_back('{32'h000C, cyc + 1 + LANES_M, "ignored pulses"});
        @(negedge clk);
        start_m = 1'b0; a_m = 16'hFFFF; b_m = 16'hFFFF;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        wait_main_drain("ignored pulses");
        repeat (6) @(negedge clk);

        // Reset in the second ACCUM cycle aborts with no done pulse
        a_m = 16'h7777; b_m = 16'h7777; sgn_m = 1'b1; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        @(negedge clk);
        rst_m = 1'b1;
        @(negedge clk);
        rst_m = 1'b0;
        check("abort ready", 32'(ready_m), 32'd1);
        check("abort done", 32'(done_m), 32'd0);
        check("abort result", 32'(result_m), 32'd0);
        repeat (8) @(negedge clk);
        do_op(16'h4321, 16'h0000, 1'b0, 16'h000A, "after abort");

        // Reset and start together: reset wins
        rst_m = 1'b1; start_m = 1'b1; a_m = 16'h7777; b_m = 16'h7777; sgn_m = 1'b1;
        @(negedge clk);
        rst_m = 1'b0; start_m = 1'b0;
        check("rst+start ready", 32'(ready_m), 32'd1);
        check("rst+start result", 32'(result_m), 32'd0);
        repeat (8) @(negedge clk);

        n = 0;
        while (!(fin8 && fin32) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n == 40000) fail_evt("regression timeout");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
